// File: rtl/hazard_pkg.sv
// Shared constants and the scoreboard entry type for the D-stage hazard unit.
// Entry field widths follow SB_AW/SB_TW; keep them equal to the top's REG_AW/T_W.
package hazard_pkg;

    localparam int SB_AW = 5;
    localparam int SB_TW = 2;

    localparam logic [2:0]       FWD_RF    = 3'd0;
    localparam logic [SB_TW-1:0] TUSE_NONE = '1;

    localparam logic [2:0] STG_E = 3'd1;
    localparam logic [2:0] STG_M = 3'd2;
    localparam logic [2:0] STG_W = 3'd3;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] addr;
        logic [SB_TW-1:0] tnew;
    } sb_entry_t;

    // One stage of ageing: a pending result gets one cycle closer, never below zero.
    function automatic logic [SB_TW-1:0] tnew_age(input logic [SB_TW-1:0] tnew);
        return (tnew == '0) ? tnew : tnew - SB_TW'(1);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy countdown: loads the unit latency on issue, counts to zero, holds.
module md_busy_counter #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: data stall, per-source forwarding selects, mult/div interlock.
// Optional HAZARD_STATS_EN adds free-running stall_cnt / md_stall_cnt counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW  = SB_AW,
    parameter int T_W     = SB_TW,
    parameter int STAGES  = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [T_W-1:0]    d_tuse_rs,
    input  logic [T_W-1:0]    d_tuse_rt,
    input  logic              d_wr_en,
    input  logic [REG_AW-1:0] d_wr_addr,
    input  logic [T_W-1:0]    d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_is_div,
    input  logic              d_md_use,
    output logic              stall,
    output logic [2:0]        fwd_rs,
    output logic [2:0]        fwd_rt,
    output logic              md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       md_stall_cnt
`endif
);

    sb_entry_t  r_sb [1:STAGES];
    sb_entry_t  w_entry_e;
    logic       w_rs_used, w_rt_used;
    logic       w_rs_stall, w_rt_stall, w_md_stall;
    logic [2:0] w_fwd_rs, w_fwd_rt;
    logic       w_md_load;

    always_comb begin
        w_entry_e = '0;
        if (!stall && d_valid && d_wr_en && (d_wr_addr != '0)) begin
            w_entry_e = '{valid: 1'b1, addr: d_wr_addr, tnew: d_tnew};
        end
    end

    // Scoreboard memory is reset: a stale valid entry after reset would raise false stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 1; k <= STAGES; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            r_sb[STG_E] <= w_entry_e;
            for (int k = 2; k <= STAGES; k++) begin
                r_sb[k] <= '{valid: r_sb[k-1].valid,
                             addr:  r_sb[k-1].addr,
                             tnew:  tnew_age(r_sb[k-1].tnew)};
            end
        end
    end

    assign w_rs_used = (d_tuse_rs != TUSE_NONE) && (d_rs != '0);
    assign w_rt_used = (d_tuse_rt != TUSE_NONE) && (d_rt != '0);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    // Scan oldest to youngest; later hits overwrite, so the youngest producer wins.
    always_comb begin
        w_rs_stall = 1'b0;
        w_rt_stall = 1'b0;
        w_fwd_rs   = FWD_RF;
        w_fwd_rt   = FWD_RF;
        for (int k = STAGES; k >= 1; k--) begin
            if (w_rs_used && r_sb[k].valid && (r_sb[k].addr == d_rs)) begin
                w_rs_stall = (r_sb[k].tnew > d_tuse_rs);
                w_fwd_rs   = (r_sb[k].tnew == '0) ? 3'(k) : FWD_RF;
            end
            if (w_rt_used && r_sb[k].valid && (r_sb[k].addr == d_rt)) begin
                w_rt_stall = (r_sb[k].tnew > d_tuse_rt);
                w_fwd_rt   = (r_sb[k].tnew == '0) ? 3'(k) : FWD_RF;
            end
        end
    end

    assign w_md_stall = d_md_use && md_busy;
    assign stall      = d_valid && (w_rs_stall || w_rt_stall || w_md_stall);
    assign fwd_rs     = d_valid ? w_fwd_rs : FWD_RF;
    assign fwd_rt     = d_valid ? w_fwd_rt : FWD_RF;
    assign w_md_load  = !stall && d_valid && d_md_start;

    md_busy_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_md_load),
        .is_div  (d_md_is_div),
        .busy    (md_busy)
    );

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt, r_md_stall_cnt;
    logic        w_md_only;

    assign w_md_only = d_valid && w_md_stall && !w_rs_stall && !w_rt_stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt    <= '0;
            r_md_stall_cnt <= '0;
        end else begin
            if (stall)     r_stall_cnt    <= r_stall_cnt + 32'd1;
            if (w_md_only) r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign md_stall_cnt = r_md_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic against an
// in-flight-queue reference model; also covers HAZARD_STATS_EN when that macro is defined.
module tb_hazard_scoreboard;

    localparam int STAGES  = 3;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_wr_addr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_wr_en, d_md_start, d_md_is_div, d_md_use;
    logic       stall, md_busy;
    logic [2:0] fwd_rs, fwd_rt;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, md_stall_cnt;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .STAGES  (STAGES),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .d_valid     (d_valid),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_wr_en     (d_wr_en),
        .d_wr_addr   (d_wr_addr),
        .d_tnew      (d_tnew),
        .d_md_start  (d_md_start),
        .d_md_is_div (d_md_is_div),
        .d_md_use    (d_md_use),
        .stall       (stall),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt),
        .md_busy     (md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one record per instruction that entered E, youngest first.
    typedef struct {
        bit valid;
        int addr;
        int tnew;
    } flight_t;

    flight_t     fl[$];
    int          cyc      = 0;
    int          md_until = 0;
    bit [31:0]   m_stall_cnt    = 0;
    bit [31:0]   m_md_stall_cnt = 0;

    task automatic model_src(input int src, input int tuse, output bit hz, output int fwd);
        int rem;
        hz  = 1'b0;
        fwd = 0;
        if (tuse == 3 || src == 0) return;
        for (int i = 0; i < fl.size(); i++) begin
            if (fl[i].valid && fl[i].addr == src) begin
                rem = fl[i].tnew - i;
                if (rem < 0) rem = 0;
                hz  = (rem > tuse);
                fwd = (rem == 0) ? i + 1 : 0;
                return;
            end
        end
    endtask

    task automatic run_cycle();
        bit      hs, ht, busy, mds, exp_stall, md_only;
        int      frs, frt;
        flight_t f;
        #1;
        model_src(d_rs, d_tuse_rs, hs, frs);
        model_src(d_rt, d_tuse_rt, ht, frt);
        busy      = (cyc < md_until);
        mds       = d_md_use && busy;
        exp_stall = d_valid && (hs || ht || mds);
        md_only   = d_valid && mds && !hs && !ht;
        if (!d_valid) begin
            frs = 0;
            frt = 0;
        end
        check("stall",   32'(stall),   32'(exp_stall));
        check("fwd_rs",  32'(fwd_rs),  32'(frs));
        check("fwd_rt",  32'(fwd_rt),  32'(frt));
        check("md_busy", 32'(md_busy), 32'(busy));
`ifdef HAZARD_STATS_EN
        check("stall_cnt",    stall_cnt,    m_stall_cnt);
        check("md_stall_cnt", md_stall_cnt, m_md_stall_cnt);
`endif
        @(posedge clk);
        if (!reset_n) begin
            fl.delete();
            md_until       = 0;
            m_stall_cnt    = 0;
            m_md_stall_cnt = 0;
        end else begin
            f.valid = !exp_stall && d_valid && d_wr_en && (d_wr_addr != 0);
            f.addr  = d_wr_addr;
            f.tnew  = d_tnew;
            fl.push_front(f);
            if (fl.size() > STAGES) void'(fl.pop_back());
            if (!exp_stall && d_valid && d_md_start)
                md_until = cyc + 1 + (d_md_is_div ? DIV_LAT : MUL_LAT);
            if (exp_stall) m_stall_cnt++;
            if (md_only)   m_md_stall_cnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drv(input bit v, input int rs, input int tus, input int rt, input int tut,
                       input bit we, input int wa, input int tn,
                       input bit mds, input bit mdd, input bit mdu);
        d_valid     = v;
        d_rs        = 5'(rs);
        d_tuse_rs   = 2'(tus);
        d_rt        = 5'(rt);
        d_tuse_rt   = 2'(tut);
        d_wr_en     = we;
        d_wr_addr   = 5'(wa);
        d_tnew      = 2'(tn);
        d_md_start  = mds;
        d_md_is_div = mdd;
        d_md_use    = mdu;
    endtask

    task automatic nop();
        drv(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall",  32'(stall),   0);
        check("rst_fwd_rs", 32'(fwd_rs),  0);
        check("rst_fwd_rt", 32'(fwd_rt),  0);
        check("rst_busy",   32'(md_busy), 0);
        run_cycle();
        reset_n = 1'b1;

        // Load-use: lw $8 tnew 2, then add reads $8 with tuse 1.
        drv(1, 0, 3, 0, 3, 1, 8, 2, 0, 0, 0);
        run_cycle();
        drv(1, 8, 1, 0, 3, 1, 13, 1, 0, 0, 0);
        #1; check("lu_stall", 32'(stall), 1);
        run_cycle();
        #1; check("lu_stall_drop", 32'(stall), 0);
        check("lu_fwd_rs", 32'(fwd_rs), 0);
        run_cycle();

        // ALU chain: add $9 tnew 1, beq reads $9 with tuse 0.
        drv(1, 0, 3, 0, 3, 1, 9, 1, 0, 0, 0);
        run_cycle();
        drv(1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        #1; check("alu_stall", 32'(stall), 1);
        run_cycle();
        #1; check("alu_stall_drop", 32'(stall), 0);
        check("alu_fwd_rs", 32'(fwd_rs), 2);
        run_cycle();

        // Youngest wins: two producers of $10, both ready; the one in E must be chosen.
        drv(1, 0, 3, 0, 3, 1, 10, 0, 0, 0, 0);
        run_cycle();
        drv(1, 0, 3, 0, 3, 1, 10, 0, 0, 0, 0);
        run_cycle();
        drv(1, 0, 3, 10, 2, 0, 0, 0, 0, 0, 0);
        #1; check("yw_stall", 32'(stall), 0);
        check("yw_fwd_rt", 32'(fwd_rt), 1);
        run_cycle();

        // $0 never hazards; an unused source (tuse all-ones) never hazards.
        drv(1, 0, 3, 0, 3, 1, 0, 2, 0, 0, 0);
        run_cycle();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; check("zero_stall", 32'(stall), 0);
        check("zero_fwd", 32'(fwd_rs), 0);
        run_cycle();
        drv(1, 0, 3, 0, 3, 1, 11, 2, 0, 0, 0);
        run_cycle();
        drv(1, 11, 3, 0, 3, 0, 0, 0, 0, 0, 0);
        #1; check("unused_stall", 32'(stall), 0);
        run_cycle();

        // Divide then mflo: stall for exactly DIV_LAT cycles; mult likewise with MUL_LAT.
        for (int pass = 0; pass < 2; pass++) begin
            nop();
            repeat (3) run_cycle();
            drv(1, 0, 3, 0, 3, 0, 0, 0, 1, (pass == 0), 1);
            run_cycle();
            drv(1, 0, 3, 0, 3, 1, 14, 0, 0, 0, 1);
            n = 0;
            for (int i = 0; i < 30; i++) begin
                #1;
                if (!stall) break;
                n++;
                run_cycle();
            end
            check(pass == 0 ? "div_stall_cycles" : "mul_stall_cycles", n,
                  pass == 0 ? DIV_LAT : MUL_LAT);
            run_cycle();
        end

        // Reset mid-flight: lw in E, divider counter at 7.
        nop();
        repeat (3) run_cycle();
        drv(1, 0, 3, 0, 3, 0, 0, 0, 1, 1, 1);
        run_cycle();
        nop();
        run_cycle();
        run_cycle();
        drv(1, 0, 3, 0, 3, 1, 12, 2, 0, 0, 0);
        run_cycle();
        reset_n = 1'b0;
        nop();
        run_cycle();
        reset_n = 1'b1;
        drv(1, 12, 0, 0, 3, 0, 0, 0, 0, 0, 1);
        #1; check("rmf_stall", 32'(stall), 0);
        check("rmf_busy", 32'(md_busy), 0);
        check("rmf_fwd", 32'(fwd_rs), 0);
`ifdef HAZARD_STATS_EN
        check("rmf_stall_cnt", stall_cnt, 0);
        check("rmf_md_cnt", md_stall_cnt, 0);
`endif
        run_cycle();

        // Random traffic on a small register window to force frequent matches.
        for (int i = 0; i < 600; i++) begin
            bit ms;
            ms = ($urandom_range(0, 15) == 0);
            reset_n = ($urandom_range(0, 99) != 0);
            drv(($urandom_range(0, 9) != 0),
                $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 3),
                ms, $urandom_range(0, 1), ms || ($urandom_range(0, 5) == 0));
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
